// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// one-entry registered response slot per requester and op-based output masking.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [CTRL_W-1:0] i_req0_ctrl,
  input  logic [WIDTH-1:0]  i_req0_a,
  input  logic [WIDTH-1:0]  i_req0_b,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [WIDTH-1:0]  o_rsp0_result,
  output logic              o_rsp0_flag,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [CTRL_W-1:0] i_req1_ctrl,
  input  logic [WIDTH-1:0]  i_req1_a,
  input  logic [WIDTH-1:0]  i_req1_b,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [WIDTH-1:0]  o_rsp1_result,
  output logic              o_rsp1_flag,

  output logic [CTRL_W-1:0] o_alu_ctrl,
  output logic [WIDTH-1:0]  o_alu_a,
  output logic [WIDTH-1:0]  o_alu_b,
  input  logic [WIDTH-1:0]  i_alu_result,
  input  logic              i_alu_flag
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  localparam logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(18);

  slot_e             slot_q   [2];
  slot_e             slot_d   [2];
  logic [WIDTH-1:0]  result_q [2];
  logic [WIDTH-1:0]  result_d [2];
  logic              flag_q   [2];
  logic              flag_d   [2];
  logic              last_q;
  logic              last_d;

  logic [1:0]        req_valid;
  logic [1:0]        rsp_ready;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              keep_result;
  logic              keep_flag;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // The ALU drives Z on outputs an op does not define; only defined ones pass.
  function automatic logic ctrl_has_result(input logic [CTRL_W-1:0] ctrl);
    return (ctrl <= CTRL_W'(9)) || (ctrl == CTRL_W'(16));
  endfunction

  function automatic logic ctrl_has_flag(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == CTRL_W'(7)) || (ctrl == CTRL_W'(8)) ||
           ((ctrl >= CTRL_W'(10)) && (ctrl <= CTRL_W'(15)));
  endfunction

  always_comb begin
    eligible = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      eligible[n] = req_valid[n] & ((slot_q[n] == SLOT_EMPTY) | rsp_ready[n]);
    end

    // last_q == 1 means req1 was granted last, so req0 wins a tie.
    grant = '0;
    if (!rst) begin
      grant[0] = eligible[0] & (~eligible[1] | last_q);
      grant[1] = eligible[1] & (~eligible[0] | ~last_q);
    end

    last_d = last_q;
    if (grant[0]) begin
      last_d = 1'b0;
    end else if (grant[1]) begin
      last_d = 1'b1;
    end

    o_alu_ctrl = CTRL_NOP;
    o_alu_a    = '0;
    o_alu_b    = '0;
    if (grant[0]) begin
      o_alu_ctrl = i_req0_ctrl;
      o_alu_a    = i_req0_a;
      o_alu_b    = i_req0_b;
    end else if (grant[1]) begin
      o_alu_ctrl = i_req1_ctrl;
      o_alu_a    = i_req1_a;
      o_alu_b    = i_req1_b;
    end

    keep_result = ctrl_has_result(o_alu_ctrl);
    keep_flag   = ctrl_has_flag(o_alu_ctrl);

    for (int unsigned n = 0; n < 2; n++) begin
      slot_d[n]   = slot_q[n];
      result_d[n] = result_q[n];
      flag_d[n]   = flag_q[n];
      if (grant[n]) begin
        slot_d[n]   = SLOT_FULL;
        result_d[n] = keep_result ? i_alu_result : '0;
        flag_d[n]   = keep_flag ? i_alu_flag : 1'b0;
      end else if (rsp_ready[n] && (slot_q[n] == SLOT_FULL)) begin
        slot_d[n]   = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      for (int unsigned n = 0; n < 2; n++) begin
        slot_q[n]   <= SLOT_EMPTY;
        result_q[n] <= '0;
        flag_q[n]   <= 1'b0;
      end
    end else begin
      last_q <= last_d;
      for (int unsigned n = 0; n < 2; n++) begin
        slot_q[n]   <= slot_d[n];
        result_q[n] <= result_d[n];
        flag_q[n]   <= flag_d[n];
      end
    end
  end

  assign o_req0_ready  = grant[0];
  assign o_req1_ready  = grant[1];
  assign o_rsp0_valid  = (slot_q[0] == SLOT_FULL);
  assign o_rsp1_valid  = (slot_q[1] == SLOT_FULL);
  assign o_rsp0_result = result_q[0];
  assign o_rsp1_result = result_q[1];
  assign o_rsp0_flag   = flag_q[0];
  assign o_rsp1_flag   = flag_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for alu_share_arbiter against a cycle-level
// reference model of the arbitration, response slots and ALU op semantics.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv [2];
  logic [4:0]  rc [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        rr [2];

  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_flag, rsp1_flag;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_flag;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic        mv    [2];
  logic [31:0] mres  [2];
  logic        mflag [2];
  logic        mlast;
  logic        obs_g [2];

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(rv[0]), .o_req0_ready(req0_ready), .i_req0_ctrl(rc[0]),
    .i_req0_a(ra[0]), .i_req0_b(rb[0]),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rr[0]),
    .o_rsp0_result(rsp0_result), .o_rsp0_flag(rsp0_flag),
    .i_req1_valid(rv[1]), .o_req1_ready(req1_ready), .i_req1_ctrl(rc[1]),
    .i_req1_a(ra[1]), .i_req1_b(rb[1]),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rr[1]),
    .o_rsp1_result(rsp1_result), .o_rsp1_flag(rsp1_flag),
    .o_alu_ctrl(alu_ctrl), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_result(alu_res), .i_alu_flag(alu_flag)
  );

  function automatic bit has_res(input logic [4:0] c);
    return (c <= 5'd9) || (c == 5'd16);
  endfunction

  function automatic bit has_flag(input logic [4:0] c);
    return (c == 5'd7) || (c == 5'd8) || (c >= 5'd10 && c <= 5'd15);
  endfunction

  function automatic logic f_flag(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      5'd7, 5'd12: return $signed(a) < $signed(b);
      5'd8, 5'd14: return a < b;
      5'd10:       return a == b;
      5'd11:       return a != b;
      5'd13:       return $signed(a) >= $signed(b);
      5'd15:       return a >= b;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_res(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a ^ b;
      5'd3:    return a + b;
      5'd4:    return a - b;
      5'd5:    return a << b[4:0];
      5'd6:    return a >> b[4:0];
      5'd7, 5'd8: return {31'd0, f_flag(c, a, b)};
      5'd9:    return $unsigned($signed(a) >>> b[4:0]);
      5'd16:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in ALU: undefined outputs carry non-zero junk in place of Z
  always_comb begin
    alu_res  = has_res(alu_ctrl) ? f_res(alu_ctrl, alu_a, alu_b) : {16'hBAD0, alu_a[15:0]};
    alu_flag = has_flag(alu_ctrl) ? f_flag(alu_ctrl, alu_a, alu_b) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: checks every output against the model, then advances the model.
  task automatic step();
    logic e [2];
    logic g [2];
    logic [4:0]  xc;
    logic [31:0] xa, xb;
    for (int n = 0; n < 2; n++) e[n] = rv[n] & (!mv[n] | rr[n]);
    g[0] = 1'b0;
    g[1] = 1'b0;
    if (!rst) begin
      if (e[0] && e[1]) begin
        g[0] = mlast;
        g[1] = !mlast;
      end else begin
        g[0] = e[0];
        g[1] = e[1];
      end
    end
    xc = 5'd18; xa = 32'd0; xb = 32'd0;
    for (int n = 0; n < 2; n++) if (g[n]) begin xc = rc[n]; xa = ra[n]; xb = rb[n]; end

    @(negedge clk);
    check("ready0", 64'(req0_ready), 64'(g[0]));
    check("ready1", 64'(req1_ready), 64'(g[1]));
    check("alu_ctrl", 64'(alu_ctrl), 64'(xc));
    check("alu_a", 64'(alu_a), 64'(xa));
    check("alu_b", 64'(alu_b), 64'(xb));
    check("rsp0_valid", 64'(rsp0_valid), 64'(mv[0]));
    check("rsp1_valid", 64'(rsp1_valid), 64'(mv[1]));
    check("rsp0_result", 64'(rsp0_result), 64'(mres[0]));
    check("rsp1_result", 64'(rsp1_result), 64'(mres[1]));
    check("rsp0_flag", 64'(rsp0_flag), 64'(mflag[0]));
    check("rsp1_flag", 64'(rsp1_flag), 64'(mflag[1]));
    obs_g[0] = req0_ready;
    obs_g[1] = req1_ready;

    @(posedge clk);
    if (rst) begin
      for (int n = 0; n < 2; n++) begin mv[n] = 0; mres[n] = 0; mflag[n] = 0; end
      mlast = 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (g[n]) begin
          mv[n] = 1'b1;
          mres[n] = f_res(rc[n], ra[n], rb[n]);
          mflag[n] = f_flag(rc[n], ra[n], rb[n]);
        end else if (rr[n] && mv[n]) begin
          mv[n] = 1'b0;
        end
      end
      if (g[0]) mlast = 1'b0;
      else if (g[1]) mlast = 1'b1;
    end
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [4:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    rv[n] = v; rc[n] = c; ra[n] = a; rb[n] = b;
  endtask

  initial begin
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      set_req(n, 1'b0, 5'd0, 32'd0, 32'd0);
      rr[n] = 1'b1;
      mv[n] = 0; mres[n] = 0; mflag[n] = 0;
      obs_g[n] = 0;
    end
    mlast = 1'b1;
    @(posedge clk); #1;
    step();
    rst = 1'b0;

    // Single ADD on req0
    set_req(0, 1'b1, 5'd3, 32'd5, 32'd7);
    step();
    check("add_ready", 64'(obs_g[0]), 64'd1);
    rv[0] = 1'b0;
    check("add_valid", 64'(rsp0_valid), 64'd1);
    check("add_result", 64'(rsp0_result), 64'd12);
    check("add_flag", 64'(rsp0_flag), 64'd0);
    step();
    check("idle_ctrl", 64'(alu_ctrl), 64'd18);

    // SUB and BEQ on req1
    set_req(1, 1'b1, 5'd4, 32'd3, 32'd5);
    step();
    rv[1] = 1'b0;
    check("sub_result", 64'(rsp1_result), 64'hFFFF_FFFE);
    check("sub_flag", 64'(rsp1_flag), 64'd0);
    set_req(1, 1'b1, 5'd10, 32'h1234, 32'h1234);
    step();
    rv[1] = 1'b0;
    check("beq_result", 64'(rsp1_result), 64'd0);
    check("beq_flag", 64'(rsp1_flag), 64'd1);

    // Tie-break after a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1'b1, 5'd3, 32'd100, 32'd1);
    set_req(1, 1'b1, 5'd2, 32'hF0F0, 32'h0FF0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("tie_g0", 64'(obs_g[0]), 64'((i % 2) == 0));
      check("tie_g1", 64'(obs_g[1]), 64'((i % 2) == 1));
    end

    // Backpressure on rsp0 must not stall req1
    rr[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mv[0]) begin
        step();
        check("bp_g0", 64'(obs_g[0]), 64'd0);
        check("bp_g1", 64'(obs_g[1]), 64'd1);
        check("bp_hold", 64'(rsp0_result), 64'd101);
      end else begin
        step();
      end
      ra[0] = 32'd200;
    end
    rr[0] = 1'b1;
    step();
    check("regrant_g0", 64'(obs_g[0]), 64'd1);
    check("regrant_valid", 64'(rsp0_valid), 64'd1);
    check("regrant_result", 64'(rsp0_result), 64'd201);

    // Reset with rsp0 full and req1 pending
    rr[0] = 1'b0;
    rst = 1'b1;
    step();
    check("rst_g0", 64'(obs_g[0]), 64'd0);
    check("rst_g1", 64'(obs_g[1]), 64'd0);
    check("rst_v0", 64'(rsp0_valid), 64'd0);
    check("rst_v1", 64'(rsp1_valid), 64'd0);
    rst = 1'b0;
    rr[0] = 1'b1;
    step();
    check("post_rst_g0", 64'(obs_g[0]), 64'd1);

    // Unsupported op is accepted with zeroed response
    rv[1] = 1'b0;
    set_req(0, 1'b1, 5'd20, 32'hCAFE_F00D, 32'h1357_9BDF);
    step();
    rv[0] = 1'b0;
    check("ebreak_result", 64'(rsp0_result), 64'd0);
    check("ebreak_flag", 64'(rsp0_flag), 64'd0);
    step();
    check("idle_ctrl2", 64'(alu_ctrl), 64'd18);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (obs_g[n] || !rv[n]) begin
          rv[n] = ($urandom % 4) != 0;
          rc[n] = 5'($urandom);
          ra[n] = $urandom;
          rb[n] = (($urandom % 4) == 0) ? ra[n] : $urandom;
          if (($urandom % 3) == 0) rb[n] = 32'($urandom % 40);
        end
        rr[n] = ($urandom % 4) != 0;
      end
      rst = ($urandom % 300) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
